// File: rtl/regfile_writer.sv
// Write-back collector: arbitrates ALU/load results into an in-order FIFO and
// drains one register-file write per cycle, publishing a pending-rd scoreboard.
module regfile_writer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        RESET,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        load_valid,
  input  logic [4:0]  load_rd,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        hold,
  input  logic        flush,
  output logic        WR_EN,
  output logic [4:0]  write_select,
  output logic [31:0] data_in,
  output logic [31:0] pending,
  output logic        idle,
  output logic [31:0] retired
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, offset;
  logic [AW:0]   count;
  logic          full, empty, take_load, take_alu, push, pop;
  logic [4:0]    push_rd;
  logic [31:0]   push_data;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign load_ready = !full && !flush;
  assign alu_ready  = !full && !flush && !load_valid;

  assign take_load = load_valid && load_ready;
  assign take_alu  = alu_valid && alu_ready;
  assign push_rd   = take_load ? load_rd   : alu_rd;
  assign push_data = take_load ? load_data : alu_data;

  // x0 results complete the handshake but never occupy a slot.
  assign push = (take_load || take_alu) && (push_rd != 5'd0);
  assign pop  = !hold && !flush && !empty;

  assign idle = empty && !WR_EN;

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      WR_EN        <= 1'b0;
      write_select <= '0;
      data_in      <= '0;
      retired      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      WR_EN  <= 1'b0;
    end else begin
      if (push) begin
        rd_q[wr_ptr]   <= push_rd;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        write_select <= rd_q[rd_ptr];
        data_in      <= data_q[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
        retired      <= retired + 32'd1;
      end
      WR_EN <= pop;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pending = '0;
    offset  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - rd_ptr;
      if ({1'b0, offset} < count)
        pending[rd_q[i]] = 1'b1;
    end
    if (WR_EN)
      pending[write_select] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Directed self-checking bench for regfile_writer (DEPTH = 4).
module tb_regfile_writer;

  logic        clock = 1'b0;
  logic        RESET;
  logic        alu_valid, load_valid, hold, flush;
  logic [4:0]  alu_rd, load_rd;
  logic [31:0] alu_data, load_data;
  logic        alu_ready, load_ready, WR_EN, idle;
  logic [4:0]  write_select;
  logic [31:0] data_in, pending, retired;

  int checks = 0;
  int failures = 0;

  regfile_writer #(.DEPTH(4)) dut (
    .clock(clock), .RESET(RESET),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(load_ready),
    .hold(hold), .flush(flush),
    .WR_EN(WR_EN), .write_select(write_select), .data_in(data_in),
    .pending(pending), .idle(idle), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    RESET = 1'b1; alu_valid = 1'b0; load_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    alu_rd = '0; load_rd = '0; alu_data = '0; load_data = '0;
    #12;
    chk("rst_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    @(negedge clock);
    RESET = 1'b0;

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk("t1_wr_en_n", {31'd0, WR_EN}, 32'd0);
    chk("t1_pending_n", pending, 32'h0000_0020);
    chk("t1_idle_n", {31'd0, idle}, 32'd0);
    step();
    chk("t1_wr_en", {31'd0, WR_EN}, 32'd1);
    chk("t1_sel", {27'd0, write_select}, 32'd5);
    chk("t1_data", data_in, 32'hDEADBEEF);
    chk("t1_pending", pending, 32'h0000_0020);
    chk("t1_retired", retired, 32'd1);
    step();
    chk("t1_wr_en_after", {31'd0, WR_EN}, 32'd0);
    chk("t1_pending_after", pending, 32'd0);
    chk("t1_idle_after", {31'd0, idle}, 32'd1);

    // Load has priority over ALU
    load_valid = 1'b1; load_rd = 5'd3; load_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    #1;
    chk("t2_load_ready", {31'd0, load_ready}, 32'd1);
    chk("t2_alu_blocked", {31'd0, alu_ready}, 32'd0);
    step();
    load_valid = 1'b0;
    #1;
    chk("t2_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("t2_pending_q", pending, 32'h0000_0008);
    step();
    alu_valid = 1'b0;
    chk("t2_wr_x3", {31'd0, WR_EN}, 32'd1);
    chk("t2_sel_x3", {27'd0, write_select}, 32'd3);
    chk("t2_data_x3", data_in, 32'h11);
    chk("t2_pending_both", pending, 32'h0000_0018);
    step();
    chk("t2_wr_x4", {31'd0, WR_EN}, 32'd1);
    chk("t2_sel_x4", {27'd0, write_select}, 32'd4);
    chk("t2_data_x4", data_in, 32'h22);
    chk("t2_retired", retired, 32'd3);
    step();
    chk("t2_wr_en_after", {31'd0, WR_EN}, 32'd0);
    chk("t2_idle", {31'd0, idle}, 32'd1);

    // Fill under hold, then drain
    hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 32'(k) << 8;
      #1;
      chk("t3_fill_ready", {31'd0, alu_ready}, 32'd1);
      step();
      chk("t3_fill_no_wr", {31'd0, WR_EN}, 32'd0);
    end
    alu_rd = 5'd5; alu_data = 32'h500;
    #1;
    chk("t3_full_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("t3_full_load_ready", {31'd0, load_ready}, 32'd0);
    chk("t3_pending", pending, 32'h0000_001E);
    hold = 1'b0;
    #1;
    chk("t3_full_on_release", {31'd0, alu_ready}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t3_drain_wr", {31'd0, WR_EN}, 32'd1);
      chk("t3_drain_sel", {27'd0, write_select}, 32'(k));
      chk("t3_drain_data", data_in, 32'(k) << 8);
      if (k == 1) chk("t3_ready_after_pop", {31'd0, alu_ready}, 32'd1);
      if (k == 2) alu_valid = 1'b0;
    end
    step();
    chk("t3_done_wr", {31'd0, WR_EN}, 32'd0);
    chk("t3_retired", retired, 32'd8);
    chk("t3_idle", {31'd0, idle}, 32'd1);

    // x0 result is swallowed
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    chk("t4_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk("t4_no_wr", {31'd0, WR_EN}, 32'd0);
    chk("t4_pending", pending, 32'd0);
    chk("t4_idle", {31'd0, idle}, 32'd1);
    step();
    chk("t4_no_wr2", {31'd0, WR_EN}, 32'd0);
    chk("t4_retired", retired, 32'd8);

    // Flush of buffered entries
    hold = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 32'(k);
      step();
    end
    alu_valid = 1'b0;
    chk("t5_pending_pre", pending, 32'h0000_01C0);
    flush = 1'b1; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
    #1;
    chk("t5_flush_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("t5_flush_load_ready", {31'd0, load_ready}, 32'd0);
    step();
    flush = 1'b0; alu_valid = 1'b0;
    chk("t5_idle", {31'd0, idle}, 32'd1);
    chk("t5_pending", pending, 32'd0);
    chk("t5_no_wr", {31'd0, WR_EN}, 32'd0);
    chk("t5_retired", retired, 32'd8);
    hold = 1'b0;
    step();
    chk("t5_no_wr_released", {31'd0, WR_EN}, 32'd0);
    chk("t5_idle_released", {31'd0, idle}, 32'd1);

    // Asynchronous reset mid-drain
    hold = 1'b1;
    for (int k = 10; k <= 12; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 32'(k);
      step();
    end
    alu_valid = 1'b0;
    hold = 1'b0;
    step();
    chk("t6_wr_pre", {31'd0, WR_EN}, 32'd1);
    chk("t6_sel_pre", {27'd0, write_select}, 32'd10);
    chk("t6_retired_pre", retired, 32'd9);
    chk("t6_pending_pre", pending, 32'h0000_1C00);
    #1;
    RESET = 1'b1;
    #1;
    chk("t6_rst_wr", {31'd0, WR_EN}, 32'd0);
    chk("t6_rst_sel", {27'd0, write_select}, 32'd0);
    chk("t6_rst_data", data_in, 32'd0);
    chk("t6_rst_retired", retired, 32'd0);
    chk("t6_rst_pending", pending, 32'd0);
    chk("t6_rst_idle", {31'd0, idle}, 32'd1);
    @(negedge clock);
    RESET = 1'b0;
    step();
    chk("t6_post_wr", {31'd0, WR_EN}, 32'd0);
    chk("t6_post_idle", {31'd0, idle}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
